// File: rtl/mcpu_ram_arbiter.sv
// Round-robin arbiter sharing the MCPU RAM data port between the load/store unit
// (port 0) and the loader/debug DMA (port 1); one single-cycle RAM access per grant.
module mcpu_ram_arbiter #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WORD_SIZE-1:0]  wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic [WORD_SIZE-1:0]  rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_SIZE-1:0]  wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [WORD_SIZE-1:0]  rdata1,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_datawr,
    input  logic [WORD_SIZE-1:0]  ram_datard,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    last_r;
    logic                    port_r;
    logic                    lat_we_r;
    logic [ADDR_WIDTH-1:0]   lat_addr_r;
    logic [WORD_SIZE-1:0]    lat_wdata_r;
    logic                    gnt0_r;
    logic                    gnt1_r;
    logic                    done0_r;
    logic                    done1_r;
    logic [WORD_SIZE-1:0]    rdata0_r;
    logic [WORD_SIZE-1:0]    rdata1_r;
    logic                    elig0_s;
    logic                    elig1_s;
    logic                    grant_s;
    logic                    pick1_s;

    // Eligibility and round-robin pick; a req coinciding with its own done is stale.
    always_comb begin
        elig0_s = req0 & ~done0_r;
        elig1_s = req1 & ~done1_r;
        grant_s = elig0_s | elig1_s;
        pick1_s = elig1_s & (~elig0_s | ~last_r);
    end

    // Next-state logic: every grant is followed by exactly one ACCESS cycle.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // RAM port drive; reset gates the strobes so an aborted access never writes.
    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = '0;
        ram_datawr = '0;
        if ((state_r == ACCESS) && !reset) begin
            ram_we     = lat_we_r;
            ram_re     = ~lat_we_r;
            ram_addr   = lat_addr_r;
            ram_datawr = lat_wdata_r;
        end else begin
            ram_we     = 1'b0;
            ram_re     = 1'b0;
            ram_addr   = '0;
            ram_datawr = '0;
        end
    end

    // State, request latch, grant/done flags and captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            port_r      <= 1'b0;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            rdata0_r    <= '0;
            rdata1_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        port_r      <= pick1_s;
                        lat_we_r    <= pick1_s ? we1 : we0;
                        lat_addr_r  <= pick1_s ? addr1 : addr0;
                        lat_wdata_r <= pick1_s ? wdata1 : wdata0;
                        gnt0_r      <= ~pick1_s;
                        gnt1_r      <= pick1_s;
                    end
                end
                ACCESS: begin
                    last_r <= port_r;
                    gnt0_r <= 1'b0;
                    gnt1_r <= 1'b0;
                    if (port_r) begin
                        done1_r <= 1'b1;
                        if (!lat_we_r) rdata1_r <= ram_datard;
                    end else begin
                        done0_r <= 1'b1;
                        if (!lat_we_r) rdata0_r <= ram_datard;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign gnt0   = gnt0_r;
    assign gnt1   = gnt1_r;
    assign done0  = done0_r;
    assign done1  = done1_r;
    assign rdata0 = rdata0_r;
    assign rdata1 = rdata1_r;
    assign busy   = (state_r == ACCESS);

endmodule
